// File: rtl/dmem_arbiter.sv
// Shares one single-port, fixed-latency data memory between the pipeline MEM stage (M)
// and the debug/program loader (D). M has priority, and D is guaranteed a turn after MAX_WAIT losses.
module dmem_arbiter #(
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic [31:0] m_rdata,
    output logic        m_done,
    output logic        StallM,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT);
    localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [2:0]  wait_cnt, wait_cnt_n;
    logic        owner_d, owner_d_n;
    logic        grant_d;
    logic        mem_en_n, mem_we_n;
    logic [31:0] mem_addr_n, mem_wdata_n;
    logic [31:0] m_rdata_n, d_rdata_n;
    logic        m_done_n, d_done_n;

    assign StallM = m_req & ~m_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wait_cnt  <= '0;
            owner_d   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m_rdata   <= '0;
            d_rdata   <= '0;
            m_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wait_cnt  <= wait_cnt_n;
            owner_d   <= owner_d_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            m_rdata   <= m_rdata_n;
            d_rdata   <= d_rdata_n;
            m_done    <= m_done_n;
            d_done    <= d_done_n;
        end
    end

    // The mem_* registers double as the latched request, so they simply hold outside IDLE.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wait_cnt_n  = wait_cnt;
        owner_d_n   = owner_d;
        mem_en_n    = 1'b0;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        m_rdata_n   = m_rdata;
        d_rdata_n   = d_rdata;
        m_done_n    = 1'b0;
        d_done_n    = 1'b0;
        grant_d     = d_req & (~m_req | (wait_cnt == WAIT_LIMIT));

        case (state)
            IDLE: begin
                if (m_req || d_req) begin
                    owner_d_n   = grant_d;
                    mem_en_n    = 1'b1;
                    mem_we_n    = grant_d ? d_we    : m_we;
                    mem_addr_n  = grant_d ? d_addr  : m_addr;
                    mem_wdata_n = grant_d ? d_wdata : m_wdata;
                    cnt_n       = LAT_LOAD;
                    state_n     = ACCESS;
                end
                // D losing to M counts toward the guard; a D grant or an idle D port clears it.
                if (d_req && !grant_d) begin
                    wait_cnt_n = wait_cnt + 3'd1;
                end else begin
                    wait_cnt_n = '0;
                end
            end
            ACCESS: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = DONE;
                    if (!mem_we) begin
                        if (owner_d) begin
                            d_rdata_n = mem_rdata;
                        end else begin
                            m_rdata_n = mem_rdata;
                        end
                    end
                    d_done_n = owner_d;
                    m_done_n = ~owner_d;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with MEM_LAT=1 for the main scenarios and
// one with MEM_LAT=3 for the latency check, each backed by a small behavioural memory.
module tb_dmem_arbiter;

    logic clk;
    logic rst;

    logic        m_req, m_we, d_req, d_we;
    logic [31:0] m_addr, m_wdata, d_addr, d_wdata;
    logic [31:0] m_rdata, d_rdata;
    logic        m_done, d_done, stall_m;
    logic        mem_en0, mem_we0;
    logic [31:0] mem_addr0, mem_wdata0, mem_rdata0;

    logic        m_req3;
    logic [31:0] m_addr3;
    logic [31:0] m_rdata3, d_rdata3;
    logic        m_done3, d_done3, stall_m3;
    logic        mem_en3, mem_we3;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

    logic [31:0] store0 [16];
    logic [31:0] store3 [16];
    int          age0 = 0;
    int          age3 = 0;

    int checks = 0;
    int errors = 0;
    int n_done;

    dmem_arbiter #(.MEM_LAT(1), .MAX_WAIT(4)) dut0 (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done), .StallM(stall_m),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    dmem_arbiter #(.MEM_LAT(3), .MAX_WAIT(4)) dut3 (
        .clk(clk), .rst(rst),
        .m_req(m_req3), .m_we(1'b0), .m_addr(m_addr3), .m_wdata(32'h0),
        .m_rdata(m_rdata3), .m_done(m_done3), .StallM(stall_m3),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(d_rdata3), .d_done(d_done3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memories: read data is valid only during the cycle ending MEM_LAT edges after mem_en rose.
    initial begin
        for (int i = 0; i < 16; i++) begin
            store0[i] = 32'hC0DE_0000 + i;
            store3[i] = 32'hC0DE_0000 + i;
        end
    end

    always @(posedge clk) begin
        if (mem_en0) age0 <= 1;
        else if (age0 != 0 && age0 < 15) age0 <= age0 + 1;
        if (mem_en0 && mem_we0) store0[mem_addr0[5:2]] <= mem_wdata0;
        if (mem_en3) age3 <= 1;
        else if (age3 != 0 && age3 < 15) age3 <= age3 + 1;
        if (mem_en3 && mem_we3) store3[mem_addr3[5:2]] <= mem_wdata3;
    end

    assign mem_rdata0 = (((mem_en0 ? 0 : age0)) == 0) ? store0[mem_addr0[5:2]] : 32'hDEAD_BEEF;
    assign mem_rdata3 = (((mem_en3 ? 0 : age3)) == 2) ? store3[mem_addr3[5:2]] : 32'hDEAD_BEEF;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] md,
                                 input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        m_req = mr; m_we = mw; m_addr = ma; m_wdata = md;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        m_req3 = 1'b0; m_addr3 = 32'h0;
        applyStimulus(1, 1, 32'h04, 32'hA5A5_A5A5, 0, 0, 32'h0, 32'h0);

        // Reset held two cycles while M requests
        tick();
        tick();
        checkOutput("rst_mem_en", {31'b0, mem_en0}, 0);
        checkOutput("rst_m_done", {31'b0, m_done}, 0);
        checkOutput("rst_m_rdata", m_rdata, 0);
        checkOutput("rst_d_rdata", d_rdata, 0);
        checkOutput("rst_mem_addr", mem_addr0, 0);
        checkOutput("rst_stall", {31'b0, stall_m}, 1);
        rst = 1'b1;

        // Write A5A5A5A5 to 0x04
        tick();
        checkOutput("wr_mem_en", {31'b0, mem_en0}, 1);
        checkOutput("wr_mem_we", {31'b0, mem_we0}, 1);
        checkOutput("wr_mem_addr", mem_addr0, 32'h04);
        checkOutput("wr_mem_wdata", mem_wdata0, 32'hA5A5_A5A5);
        checkOutput("wr_no_done_yet", {31'b0, m_done}, 0);
        tick();
        checkOutput("wr_m_done", {31'b0, m_done}, 1);
        checkOutput("wr_mem_en_low", {31'b0, mem_en0}, 0);
        checkOutput("wr_stall_low", {31'b0, stall_m}, 0);
        checkOutput("wr_rdata_keep", m_rdata, 0);
        applyStimulus(1, 0, 32'h04, 32'h0, 0, 0, 32'h0, 32'h0);

        // Read 0x04 back
        tick();
        checkOutput("rd_done_one_cycle", {31'b0, m_done}, 0);
        checkOutput("rd_stall_idle", {31'b0, stall_m}, 1);
        tick();
        checkOutput("rd_mem_en", {31'b0, mem_en0}, 1);
        checkOutput("rd_mem_we", {31'b0, mem_we0}, 0);
        checkOutput("rd_stall_access", {31'b0, stall_m}, 1);
        tick();
        checkOutput("rd_m_done", {31'b0, m_done}, 1);
        checkOutput("rd_m_rdata", m_rdata, 32'hA5A5_A5A5);
        checkOutput("rd_stall_done", {31'b0, stall_m}, 0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        tick();
        checkOutput("rd_rdata_hold", m_rdata, 32'hA5A5_A5A5);
        checkOutput("rd_done_clear", {31'b0, m_done}, 0);

        // Simultaneous requests: M first, then D
        applyStimulus(1, 0, 32'h08, 32'h0, 1, 0, 32'h10, 32'h0);
        tick();
        checkOutput("sim_m_first_addr", mem_addr0, 32'h08);
        tick();
        checkOutput("sim_m_done", {31'b0, m_done}, 1);
        checkOutput("sim_d_not_done", {31'b0, d_done}, 0);
        checkOutput("sim_m_rdata", m_rdata, 32'hC0DE_0002);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
        tick();
        checkOutput("sim_gap_d_done", {31'b0, d_done}, 0);
        checkOutput("sim_gap_mem_en", {31'b0, mem_en0}, 0);
        tick();
        checkOutput("sim_d_addr", mem_addr0, 32'h10);
        checkOutput("sim_d_mem_en", {31'b0, mem_en0}, 1);
        tick();
        checkOutput("sim_d_done", {31'b0, d_done}, 1);
        checkOutput("sim_m_quiet", {31'b0, m_done}, 0);
        checkOutput("sim_d_rdata", d_rdata, 32'hC0DE_0004);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        tick();

        // Starvation guard: both held, expect M x4 then D, repeating
        applyStimulus(1, 0, 32'h08, 32'h0, 1, 0, 32'h10, 32'h0);
        n_done = 0;
        for (int c = 0; c < 60 && n_done < 10; c++) begin
            tick();
            if (m_done || d_done) begin
                checkOutput("starve_excl", {31'b0, m_done & d_done}, 0);
                checkOutput($sformatf("starve_win%0d", n_done), {31'b0, d_done}, (n_done % 5 == 4) ? 1 : 0);
                n_done++;
            end
        end
        checkOutput("starve_count", n_done, 10);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        tick();

        // Reset during ACCESS abandons the access; re-issue completes
        applyStimulus(1, 0, 32'h04, 32'h0, 0, 0, 32'h0, 32'h0);
        tick();
        checkOutput("mid_mem_en", {31'b0, mem_en0}, 1);
        rst = 1'b0;
        tick();
        checkOutput("mid_rst_mem_en", {31'b0, mem_en0}, 0);
        checkOutput("mid_rst_no_done", {31'b0, m_done}, 0);
        checkOutput("mid_rst_m_rdata", m_rdata, 0);
        checkOutput("mid_rst_d_rdata", d_rdata, 0);
        rst = 1'b1;
        tick();
        checkOutput("reissue_mem_en", {31'b0, mem_en0}, 1);
        checkOutput("reissue_no_done", {31'b0, m_done}, 0);
        tick();
        checkOutput("reissue_done", {31'b0, m_done}, 1);
        checkOutput("reissue_rdata", m_rdata, 32'hA5A5_A5A5);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        tick();

        // MEM_LAT=3 read of 0x0C
        m_req3 = 1'b1; m_addr3 = 32'h0C;
        tick();
        checkOutput("lat3_mem_en", {31'b0, mem_en3}, 1);
        checkOutput("lat3_addr", mem_addr3, 32'h0C);
        tick();
        checkOutput("lat3_en_drop", {31'b0, mem_en3}, 0);
        checkOutput("lat3_early1", {31'b0, m_done3}, 0);
        tick();
        checkOutput("lat3_early2", {31'b0, m_done3}, 0);
        tick();
        checkOutput("lat3_done", {31'b0, m_done3}, 1);
        checkOutput("lat3_rdata", m_rdata3, 32'hC0DE_0003);
        m_req3 = 1'b0;
        tick();
        checkOutput("lat3_done_clear", {31'b0, m_done3}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
